video_timing_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 51 +++++
 rtl/video_pattern_gen.sv | 39 +++
 rtl/video_timing_gen.sv | 165 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared timing defaults, pattern encodings and bar colours for the
// video timing generator (optional VIDEO_TIMING_GEN_SCROLL_EN scroll).
package video_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CHECK_LOG2 = 3;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pat_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    unique case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern lookup: (x, y, sel, solid, frame_cnt) -> pixel.
// frame_cnt offsets gradient R; the top ties it to 0 without scrolling.
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int XW         = 10,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int CHECK_LOG2 = DEF_CHECK_LOG2
) (
  input  logic [XW-1:0] x,
  input  logic [7:0]    y,
  input  pat_e          sel,
  input  logic [23:0]   solid,
  input  logic [7:0]    frame_cnt,
  output logic [23:0]   pixel
);

  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [XW-1:0] bar_raw;
  logic [2:0]    bar_idx;
  logic [7:0]    x8;

  always_comb begin
    x8      = 8'(x);
    bar_raw = x / XW'(BAR_W);
    // last bar absorbs any remainder columns
    bar_idx = (bar_raw > XW'(7)) ? 3'd7 : 3'(bar_raw);
    pixel   = '0;
    unique case (sel)
      PAT_BARS:  pixel = bar_colour(bar_idx);
      PAT_GRAD:  pixel = {x8 + frame_cnt, y, x8 + y};
      PAT_CHECK: pixel = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ?
                         24'hFFFFFF : 24'h000000;
      PAT_SOLID: pixel = solid;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with registered sync/en/data/sof outputs.
// Define VIDEO_TIMING_GEN_SCROLL_EN for a per-frame scrolling gradient.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int CHECK_LOG2 = DEF_CHECK_LOG2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        en,
  output logic [23:0] data,
  output logic        sof
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  state_e        st_q, st_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  pat_e          sel_q, sel_d;
  logic [23:0]   solid_q, solid_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          en_q, en_d;
  logic          sof_q, sof_d;
  logic [23:0]   data_q, data_d;
  logic          frame_start;
  logic          active;
  logic [7:0]    frame_cnt;
  logic [23:0]   pix;

`ifdef VIDEO_TIMING_GEN_SCROLL_EN
  logic [7:0] frm_q, frm_d;

  always_comb begin
    frm_d = frm_q + (frame_start ? 8'd1 : 8'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) frm_q <= '0;
    else     frm_q <= frm_d;
  end

  assign frame_cnt = frm_q;
`else
  assign frame_cnt = 8'd0;
`endif

  video_pattern_gen #(
    .XW        (HW),
    .H_ACTIVE  (H_ACTIVE),
    .CHECK_LOG2(CHECK_LOG2)
  ) u_pat (
    .x        (h_q),
    .y        (8'(v_q)),
    .sel      (sel_q),
    .solid    (solid_q),
    .frame_cnt(frame_cnt),
    .pixel    (pix)
  );

  always_comb begin
    st_d        = st_q;
    h_d         = h_q;
    v_d         = v_q;
    sel_d       = sel_q;
    solid_d     = solid_q;
    frame_start = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (run) begin
          st_d        = ST_RUN;
          frame_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d = '0;
            // a frame is never cut short; run only matters here
            if (run) frame_start = 1'b1;
            else     st_d = ST_IDLE;
          end else begin
            v_d = v_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    if (frame_start) begin
      sel_d   = pat_e'(pattern_sel);
      solid_d = solid_rgb;
    end

    active  = (st_q == ST_RUN);
    en_d    = active && (h_q < H_ACT) && (v_q < V_ACT);
    hsync_d = active && (h_q >= HS_BEG) && (h_q <= HS_END);
    vsync_d = active && (v_q >= VS_BEG) && (v_q <= VS_END);
    sof_d   = en_d && (h_q == '0) && (v_q == '0);
    data_d  = en_d ? pix : 24'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      sel_q   <= PAT_BARS;
      solid_q <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      en_q    <= 1'b0;
      sof_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      st_q    <= st_d;
      h_q     <= h_d;
      v_q     <= v_d;
      sel_q   <= sel_d;
      solid_q <= solid_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      en_q    <= en_d;
      sof_q   <= sof_d;
      data_q  <= data_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign en    = en_q;
  assign sof   = sof_q;
  assign data  = data_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 15x8 raster (H 8/2/3/2,
// V 4/1/2/1, checker square 2 pixels); honours VIDEO_TIMING_GEN_SCROLL_EN.
module tb_video_timing_gen;

`ifdef VIDEO_TIMING_GEN_SCROLL_EN
  localparam int SCROLL = 1;
`else
  localparam int SCROLL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [23:0] solid = 24'h0;
  logic        hsync, vsync, en, sof;
  logic [23:0] data;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [23:0] line0 [8];
  logic [23:0] px32;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CHECK_LOG2(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .pattern_sel(sel),
    .solid_rgb  (solid),
    .hsync      (hsync),
    .vsync      (vsync),
    .en         (en),
    .data       (data),
    .sof        (sof)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bar_ref(input int x);
    case (x)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] exp_pix(input int mode, input int x,
                                          input int y, input int fc);
    logic [7:0] r;
    r = 8'(x + SCROLL * fc);
    case (mode)
      0:       return bar_ref(x);
      1:       return {r, 8'(y), 8'(x + y)};
      2:       return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ?
                      24'hFFFFFF : 24'h000000;
      default: return 24'h123456;
    endcase
  endfunction

  // Caller has already ticked to frame clock 0; walks up to stop_at.
  task automatic run_frame(input string name, input int mode, input int fc,
                           input int drop_at, input int chg_at,
                           input logic [1:0] new_sel, input int stop_at);
    int en_bad  = 0;
    int hs_bad  = 0;
    int vs_bad  = 0;
    int sof_bad = 0;
    int pix_bad = 0;
    int en_cnt  = 0;
    int vs_cnt  = 0;
    for (int k = 0; k <= stop_at; k++) begin
      int h;
      int v;
      logic e;
      logic [23:0] ep;
      h = k % 15;
      v = k / 15;
      if (k > 0) tick();
      e  = (h < 8) && (v < 4);
      ep = e ? exp_pix(mode, h, v, fc) : 24'h0;
      if (en !== e) en_bad++;
      if (hsync !== ((h >= 10) && (h <= 12))) hs_bad++;
      if (vsync !== ((v >= 5) && (v <= 6))) vs_bad++;
      if (sof !== (k == 0)) sof_bad++;
      if (data !== ep) pix_bad++;
      if (en === 1'b1) en_cnt++;
      if (vsync === 1'b1) vs_cnt++;
      if (v == 0 && h < 8) line0[h] = data;
      if (h == 3 && v == 2) px32 = data;
      if (k == drop_at) run = 1'b0;
      if (k == chg_at) begin
        sel   = new_sel;
        solid = 24'h123456;
      end
    end
    chk({name, "_en_bad"}, en_bad, 0);
    chk({name, "_hsync_bad"}, hs_bad, 0);
    chk({name, "_vsync_bad"}, vs_bad, 0);
    chk({name, "_sof_bad"}, sof_bad, 0);
    chk({name, "_pix_bad"}, pix_bad, 0);
    if (stop_at == 119) begin
      chk({name, "_en_count"}, en_cnt, 32);
      chk({name, "_vsync_count"}, vs_cnt, 30);
    end
  endtask

  initial begin
    int busy;
    run = 1'b1;
    tick();
    tick();
    chk("reset_outputs", {hsync, vsync, en, sof, data}, 0);

    rst = 1'b0;
    tick();
    chk("first_en_edge1", en, 0);
    tick();
    chk("first_en_edge2", en, 1);
    chk("first_sof", sof, 1);

    run_frame("f1_bars", 0, 1, -1, -1, 2'd0, 119);
    chk("bar0", line0[0], 24'hFFFFFF);
    chk("bar1", line0[1], 24'hFFFF00);
    chk("bar2", line0[2], 24'h00FFFF);
    chk("bar3", line0[3], 24'h00FF00);
    chk("bar4", line0[4], 24'hFF00FF);
    chk("bar5", line0[5], 24'hFF0000);
    chk("bar6", line0[6], 24'h0000FF);
    chk("bar7", line0[7], 24'h000000);

    tick();
    run_frame("f2_bars_latch", 0, 2, -1, 40, 2'd3, 119);
    tick();
    run_frame("f3_solid_stop", 3, 3, 40, -1, 2'd0, 119);

    busy = 0;
    repeat (120) begin
      tick();
      if ({hsync, vsync, en, sof} !== 4'b0 || data !== 24'h0) busy++;
    end
    chk("idle_quiet", busy, 0);

    sel = 2'd2;
    run = 1'b1;
    tick();
    chk("restart_edge1_sof", sof, 0);
    tick();
    chk("restart_edge2_sof", sof, 1);
    run_frame("f4_checker", 2, 4, -1, 50, 2'd1, 119);

    tick();
    run_frame("f5_grad_part", 1, 5, -1, -1, 2'd1, 60);
    chk("grad_px32_f5", px32,
        SCROLL != 0 ? 24'h080205 : 24'h030205);

    rst = 1'b1;
    tick();
    chk("midframe_reset_outputs", {hsync, vsync, en, sof, data}, 0);
    rst = 1'b0;
    tick();
    chk("post_reset_edge1_en", en, 0);
    tick();
    chk("post_reset_edge2_en", en, 1);
    run_frame("f6_grad", 1, 1, -1, -1, 2'd1, 119);
    chk("grad_px32_f6", px32,
        SCROLL != 0 ? 24'h040205 : 24'h030205);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
